immpicker_stage: RTL and testbench

- Registered, flow-controlled successor to the combinational immediate extractor; sits between instruction fetch/decode and the execute operand mux.
- Accepts a 32-bit RISC-V instruction plus one-hot format selects and emits the sign/zero-extended immediate one cycle later.
- Uses a valid/ready handshake on both sides, with an optional skid register so ready_o is registered.
- Generalised in width (XLEN), adds CSR zimm format, illegal-select detection, and back-pressure buffering.

---
 rtl/immpicker_stage.sv | 133 +++++++++++++
 tb/tb_immpicker_stage.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/immpicker_stage.sv
// immpicker_stage: registered immediate extractor for RISC-V instruction words.
// Decodes one of the I/S/SB/U/UJ/Z(CSR zimm) formats, sign- or zero-extends the
// result to XLEN and hands it downstream one cycle after acceptance.
//
// Handshake: a transfer happens on any rising edge where valid and ready are both
// high on that interface. A producer holds its valid and data stable until the
// transfer; ready may change freely. valid_o never drops without an output
// transfer (or reset), and value_o/illegal_o stay stable while it waits.
module immpicker_stage #(
  parameter int unsigned XLEN = 64,
  parameter bit          SKID = 1'b1
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [31:0]     instruction_i,
  input  logic            typeI_i,
  input  logic            typeS_i,
  input  logic            typeSB_i,
  input  logic            typeU_i,
  input  logic            typeUJ_i,
  input  logic            typeZ_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] value_o,
  output logic            illegal_o,
  output logic [1:0]      dbgState_o
);

  // EMPTY: nothing held; ONE: output register full; TWO: output and skid full.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state;
  logic              readyReg;
  logic [XLEN-1:0]   skidValue;
  logic              skidIllegal;
  logic [XLEN-1:0]   newValue;
  logic              newIllegal;
  logic [5:0]        sel;
  logic              multiSel;
  logic              inXfer;
  logic              outXfer;

  assign valid_o    = (state != EMPTY);
  assign dbgState_o = state;
  // With the skid buffer ready is a flop; without it the single register can
  // accept whenever it is empty or being drained this cycle.
  assign ready_o    = SKID ? readyReg : (!valid_o || ready_i);
  assign inXfer     = valid_i && ready_o;
  assign outXfer    = valid_o && ready_i;

  // Decode the immediate for the instruction currently offered upstream.
  always_comb begin
    sel        = {typeI_i, typeS_i, typeSB_i, typeU_i, typeUJ_i, typeZ_i};
    // Clearing the lowest set bit leaves something only if two or more are set.
    multiSel   = ((sel & (sel - 6'd1)) != 6'd0);
    newValue   = '0;
    newIllegal = 1'b0;
    if (multiSel) begin
      newIllegal = 1'b1;
    end else if (typeI_i) begin
      newValue = XLEN'($signed(instruction_i[31:20]));
    end else if (typeS_i) begin
      newValue = XLEN'($signed({instruction_i[31:25], instruction_i[11:7]}));
    end else if (typeSB_i) begin
      newValue = XLEN'($signed({instruction_i[31], instruction_i[7],
                                instruction_i[30:25], instruction_i[11:8], 1'b0}));
    end else if (typeU_i) begin
      // For XLEN=32 this cast is an identity: the upper immediate fills the word.
      newValue = XLEN'($signed({instruction_i[31:12], 12'b0}));
    end else if (typeUJ_i) begin
      newValue = XLEN'($signed({instruction_i[31], instruction_i[19:12],
                                instruction_i[20], instruction_i[30:21], 1'b0}));
    end else if (typeZ_i) begin
      newValue = XLEN'(instruction_i[19:15]);
    end
  end

  // Occupancy FSM: output register, skid register and the registered ready.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= EMPTY;
      value_o     <= '0;
      illegal_o   <= 1'b0;
      skidValue   <= '0;
      skidIllegal <= 1'b0;
      readyReg    <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (inXfer) begin
            value_o   <= newValue;
            illegal_o <= newIllegal;
            state     <= ONE;
          end
        end
        ONE: begin
          if (inXfer && outXfer) begin
            // Drain and refill in the same edge: new result bypasses the skid.
            value_o   <= newValue;
            illegal_o <= newIllegal;
          end else if (inXfer) begin
            // Output is stalled; park the new result and stop accepting.
            skidValue   <= newValue;
            skidIllegal <= newIllegal;
            readyReg    <= 1'b0;
            state       <= TWO;
          end else if (outXfer) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          if (outXfer) begin
            value_o   <= skidValue;
            illegal_o <= skidIllegal;
            readyReg  <= 1'b1;
            state     <= ONE;
          end
        end
        default: begin
          state    <= EMPTY;
          readyReg <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_immpicker_stage.sv
// tb_immpicker_stage: two instances share instruction/select/reset stimulus:
// dutA (XLEN=64, skid buffer) and dutB (XLEN=32, no skid). Each has its own
// valid/ready so both handshake styles are exercised side by side.
module tb_immpicker_stage;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i;
  logic [31:0] instr;
  logic        tI, tS, tSB, tU, tUJ, tZ;
  logic        vA, vB, rdyAi, rdyBi;
  logic        rdyAo, rdyBo, valA, valB, illA, illB;
  logic [63:0] valueA;
  logic [31:0] valueB;
  logic [1:0]  stA, stB;

  immpicker_stage #(.XLEN(64), .SKID(1'b1)) dutA (
    .clk_i(clk), .reset_i(reset_i), .valid_i(vA), .ready_o(rdyAo),
    .instruction_i(instr), .typeI_i(tI), .typeS_i(tS), .typeSB_i(tSB),
    .typeU_i(tU), .typeUJ_i(tUJ), .typeZ_i(tZ), .valid_o(valA),
    .ready_i(rdyAi), .value_o(valueA), .illegal_o(illA), .dbgState_o(stA)
  );

  immpicker_stage #(.XLEN(32), .SKID(1'b0)) dutB (
    .clk_i(clk), .reset_i(reset_i), .valid_i(vB), .ready_o(rdyBo),
    .instruction_i(instr), .typeI_i(tI), .typeS_i(tS), .typeSB_i(tSB),
    .typeU_i(tU), .typeUJ_i(tUJ), .typeZ_i(tZ), .valid_o(valB),
    .ready_i(rdyBi), .value_o(valueB), .illegal_o(illB), .dbgState_o(stB)
  );

  // ---------------- scoreboard state ----------------
  logic [64:0] expA_q[$];
  logic [32:0] expB_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int modeA = 0;   // 0: ready_i=1, 1: random, 2: ready_i=0
  int modeB = 0;
  bit recording = 1'b0;
  int firstAccA = -1;
  int firstAccB = -1;
  int outCycA_q[$];
  int outCycB_q[$];
  int outCountA = 0;
  int outCountB = 0;

  localparam logic [5:0] SEL_I  = 6'b100000;
  localparam logic [5:0] SEL_S  = 6'b010000;
  localparam logic [5:0] SEL_SB = 6'b001000;
  localparam logic [5:0] SEL_U  = 6'b000100;
  localparam logic [5:0] SEL_UJ = 6'b000010;
  localparam logic [5:0] SEL_Z  = 6'b000001;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: immediates computed as plain integers from the field layout.
  function automatic logic [64:0] refImm(input logic [31:0] ir, input logic [5:0] sel,
                                         input int xlen);
    longint v;
    int n;
    logic [63:0] r;
    n = 0;
    for (int k = 0; k < 6; k++) n += int'(sel[k]);
    if (n > 1) return {1'b1, 64'd0};
    v = 0;
    if (sel[5]) begin
      v = longint'(ir[31:20]);
      if (v >= 2048) v -= 4096;
    end else if (sel[4]) begin
      v = longint'(ir[31:25]) * 32 + longint'(ir[11:7]);
      if (v >= 2048) v -= 4096;
    end else if (sel[3]) begin
      v = longint'(ir[31]) * 4096 + longint'(ir[7]) * 2048 +
          longint'(ir[30:25]) * 32 + longint'(ir[11:8]) * 2;
      if (v >= 4096) v -= 8192;
    end else if (sel[2]) begin
      v = longint'(ir[31:12]) * 4096;
      if (v >= 64'sh80000000) v -= 64'sh100000000;
    end else if (sel[1]) begin
      v = longint'(ir[31]) * 1048576 + longint'(ir[19:12]) * 4096 +
          longint'(ir[20]) * 2048 + longint'(ir[30:21]) * 2;
      if (v >= 1048576) v -= 2097152;
    end else if (sel[0]) begin
      v = longint'(ir[19:15]);
    end
    r = 64'(v);
    if (xlen == 32) r[63:32] = 32'd0;
    return {1'b0, r};
  endfunction

  function automatic logic [31:0] mkI(input int k);
    logic [11:0] imm;
    imm = 12'(k);
    return {imm, 20'h00013};
  endfunction

  // ---------------- ready_i generators ----------------
  always @(posedge clk) begin
    #2;
    case (modeA)
      0:       rdyAi = 1'b1;
      1:       rdyAi = 1'($urandom_range(0, 1));
      default: rdyAi = 1'b0;
    endcase
    case (modeB)
      0:       rdyBi = 1'b1;
      1:       rdyBi = 1'($urandom_range(0, 1));
      default: rdyBi = 1'b0;
    endcase
  end

  // ---------------- monitors ----------------
  logic        prevStallA = 1'b0;
  logic [64:0] prevOutA;
  always @(negedge clk) begin : monA
    logic [64:0] e;
    if (!reset_i) begin
      if (valA && prevStallA) chk("hold_A", {illA, valueA}, prevOutA);
      if (valA && rdyAi) begin
        if (expA_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_A_unexpected: got %h, expected no output", {illA, valueA});
        end else begin
          e = expA_q.pop_front();
          chk("out_A", {illA, valueA}, e);
        end
        outCountA++;
        if (recording) outCycA_q.push_back(cyc);
      end
      prevStallA = valA && !rdyAi;
      prevOutA   = {illA, valueA};
    end else begin
      prevStallA = 1'b0;
    end
  end

  logic        prevStallB = 1'b0;
  logic [32:0] prevOutB;
  always @(negedge clk) begin : monB
    logic [32:0] e;
    if (!reset_i) begin
      if (valB && prevStallB) chk("hold_B", 65'({illB, valueB}), 65'(prevOutB));
      if (valB && rdyBi) begin
        if (expB_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_B_unexpected: got %h, expected no output", {illB, valueB});
        end else begin
          e = expB_q.pop_front();
          chk("out_B", 65'({illB, valueB}), 65'(e));
        end
        outCountB++;
        if (recording) outCycB_q.push_back(cyc);
      end
      prevStallB = valB && !rdyBi;
      prevOutB   = {illB, valueB};
    end else begin
      prevStallB = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Offer one instruction to the instances selected by mask ({A,B}); returns
  // at posedge+1 after every selected instance has accepted it.
  task automatic send(input logic [31:0] ir, input logic [5:0] sel, input logic [1:0] mask,
                      input bit useExp, input logic [64:0] expA, input logic [32:0] expB);
    bit doneA, doneB;
    int budget;
    logic [64:0] rb;
    instr = ir;
    {tI, tS, tSB, tU, tUJ, tZ} = sel;
    vA = mask[1];
    vB = mask[0];
    doneA = !mask[1];
    doneB = !mask[0];
    budget = 0;
    while (!(doneA && doneB)) begin
      @(negedge clk);
      if (vA && rdyAo) begin
        expA_q.push_back(useExp ? expA : refImm(ir, sel, 64));
        doneA = 1'b1;
        if (recording && firstAccA < 0) firstAccA = cyc;
      end
      if (vB && rdyBo) begin
        rb = refImm(ir, sel, 32);
        expB_q.push_back(useExp ? expB : {rb[64], rb[31:0]});
        doneB = 1'b1;
        if (recording && firstAccB < 0) firstAccB = cyc;
      end
      @(posedge clk);
      #1;
      if (doneA) vA = 1'b0;
      if (doneB) vB = 1'b0;
      budget++;
      if (budget > 200 && !(doneA && doneB)) begin
        checks++; errors++;
        $display("FAIL send_timeout: accepted A=%0d B=%0d, expected both", doneA, doneB);
        doneA = 1'b1; doneB = 1'b1; vA = 1'b0; vB = 1'b0;
      end
    end
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((expA_q.size() != 0 || expB_q.size() != 0) && b < 500) begin
      @(negedge clk);
      b++;
    end
    if (expA_q.size() != 0 || expB_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: pending A=%0d B=%0d, expected 0", expA_q.size(), expB_q.size());
      expA_q.delete();
      expB_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int cnt;
    logic [5:0] sel;
    reset_i = 1'b1;
    instr = 32'd0;
    {tI, tS, tSB, tU, tUJ, tZ} = 6'd0;
    vA = 1'b0; vB = 1'b0; rdyAi = 1'b1; rdyBi = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #2 reset_i = 1'b0;
    @(negedge clk);
    chk("reset_valid_A", 65'(valA), 65'd0);
    chk("reset_value_A", 65'(valueA), 65'd0);
    chk("reset_illegal_A", 65'(illA), 65'd0);
    chk("reset_ready_A", 65'(rdyAo), 65'd1);
    chk("reset_valid_B", 65'(valB), 65'd0);
    chk("reset_value_B", 65'(valueB), 65'd0);
    chk("reset_ready_B", 65'(rdyBo), 65'd1);
    @(posedge clk); #1;

    // Directed format sweep with known immediates.
    send(32'h555FFFFF, SEL_I, 2'b11, 1, {1'b0, 64'h0000_0000_0000_0555}, {1'b0, 32'h0000_0555});
    send(32'hAAAFFFFF, SEL_I, 2'b11, 1, {1'b0, 64'hFFFF_FFFF_FFFF_FAAA}, {1'b0, 32'hFFFF_FAAA});
    send(32'b1010101_11111_11111_111_01010_1111111, SEL_S, 2'b11, 1,
         {1'b0, 64'hFFFF_FFFF_FFFF_FAAA}, {1'b0, 32'hFFFF_FAAA});
    send(32'b1010101_11111_11111_111_01010_1111111, SEL_SB, 2'b11, 1,
         {1'b0, 64'hFFFF_FFFF_FFFF_F2AA}, {1'b0, 32'hFFFF_F2AA});
    send(32'b10101010101010101010_11111_1111111, SEL_U, 2'b11, 1,
         {1'b0, 64'hFFFF_FFFF_AAAA_A000}, {1'b0, 32'hAAAA_A000});
    send(32'b10101010101010101010_11111_1111111, SEL_UJ, 2'b11, 1,
         {1'b0, 64'hFFFF_FFFF_FFFA_A2AA}, {1'b0, 32'hFFFA_A2AA});
    send(32'hFFFFFFFF, SEL_Z, 2'b11, 1, {1'b0, 64'h1F}, {1'b0, 32'h1F});
    send(32'hFFFFFFFF, SEL_I | SEL_S, 2'b11, 1, {1'b1, 64'd0}, {1'b1, 32'd0});
    send(32'hFFFFFFFF, 6'd0, 2'b11, 1, {1'b0, 64'd0}, {1'b0, 32'd0});
    drain();

    // Continuous stream: 8 results on 8 consecutive cycles.
    recording = 1'b1;
    firstAccA = -1;
    firstAccB = -1;
    for (int i = 0; i < 8; i++) send($urandom, SEL_I, 2'b11, 0, 65'd0, 33'd0);
    drain();
    recording = 1'b0;
    chk("stream_count_A", 65'(outCycA_q.size()), 65'd8);
    chk("stream_count_B", 65'(outCycB_q.size()), 65'd8);
    for (int i = 0; i < outCycA_q.size(); i++)
      chk("stream_cycle_A", 65'(outCycA_q[i]), 65'(firstAccA + 1 + i));
    for (int i = 0; i < outCycB_q.size(); i++)
      chk("stream_cycle_B", 65'(outCycB_q[i]), 65'(firstAccB + 1 + i));

    // Back-pressure into the skid buffer on dutA.
    modeA = 2;
    @(posedge clk); #1;
    instr = mkI(1); {tI, tS, tSB, tU, tUJ, tZ} = SEL_I; vA = 1'b1;
    @(negedge clk);
    chk("bp_ready_1", 65'(rdyAo), 65'd1);
    expA_q.push_back({1'b0, 64'd1});
    @(posedge clk); #1 instr = mkI(2);
    @(negedge clk);
    chk("bp_ready_2", 65'(rdyAo), 65'd1);
    expA_q.push_back({1'b0, 64'd2});
    @(posedge clk); #1 instr = mkI(3);
    @(negedge clk);
    chk("bp_ready_drop", 65'(rdyAo), 65'd0);
    chk("bp_valid_hold", 65'(valA), 65'd1);
    chk("bp_value_hold", 65'(valueA), 65'd1);
    modeA = 0;
    @(negedge clk);
    chk("bp_ready_still_low", 65'(rdyAo), 65'd0);
    @(negedge clk);
    chk("bp_ready_reassert", 65'(rdyAo), 65'd1);
    expA_q.push_back({1'b0, 64'd3});
    @(posedge clk); #1 vA = 1'b0;
    drain();

    // Asynchronous reset with both entries of dutA occupied.
    modeA = 2;
    @(posedge clk); #1;
    send(mkI(5), SEL_I, 2'b10, 0, 65'd0, 33'd0);
    send(mkI(6), SEL_I, 2'b10, 0, 65'd0, 33'd0);
    @(negedge clk);
    chk("pre_reset_ready", 65'(rdyAo), 65'd0);
    chk("pre_reset_valid", 65'(valA), 65'd1);
    #2 reset_i = 1'b1;
    expA_q.delete();
    expB_q.delete();
    #1;
    chk("rst_valid", 65'(valA), 65'd0);
    chk("rst_value", 65'(valueA), 65'd0);
    chk("rst_illegal", 65'(illA), 65'd0);
    chk("rst_ready", 65'(rdyAo), 65'd1);
    modeA = 0;
    @(posedge clk);
    @(negedge clk); #2 reset_i = 1'b0;
    cnt = outCountA;
    @(posedge clk); #1;
    send(mkI(7), SEL_I, 2'b10, 0, 65'd0, 33'd0);
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_single", 65'(outCountA - cnt), 65'd1);

    // Randomized traffic with random back-pressure on both instances.
    modeA = 1;
    modeB = 1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        7:       sel = 6'd0;
        8, 9:    sel = 6'($urandom_range(0, 63));
        default: sel = 6'b000001 << $urandom_range(0, 5);
      endcase
      send($urandom, sel, 2'b11, 0, 65'd0, 33'd0);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    modeA = 0;
    modeB = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
